// File: rtl/game_pkg.sv
// Shared types and constants for the Finger-Dancer round sequencer.
package game_pkg;

  // Game-level phases of the round sequencer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PLAY,
    ST_GAP,
    ST_OVER
  } state_t;

  // Width of every phase-length quantity (countdown, play window, gap).
  localparam int unsigned PHASE_W = 4;

  // Width of the lives counter (supports up to 7 lives).
  localparam int unsigned LIVES_W = 3;

  // Default timing and scoring constants.
  localparam int unsigned DEF_LIVES      = 3;
  localparam int unsigned DEF_START_TIME = 8;
  localparam int unsigned DEF_MIN_TIME   = 2;
  localparam int unsigned DEF_GAP_TICKS  = 4;
  localparam int unsigned DEF_SCORE_W    = 8;

endpackage

// File: rtl/phase_counter.sv
// Loadable 4-bit down-counter shared by the COUNT, PLAY and GAP phases.
// A load always wins over a tick in the same cycle, so a phase entry is
// never shortened by the tick that caused it.
module phase_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_value,
  input  logic               en,
  output logic [PHASE_W-1:0] remaining,
  output logic               expire
);

  // Last tick of the running phase.
  assign expire = en && (remaining == PHASE_W'(1));

  // Counter register: load has priority, then gated decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (en && (remaining != '0)) begin
      remaining <= remaining - PHASE_W'(1);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-level controller for Finger-Dancer: sequences countdown, play
// windows and inter-round gaps, keeps score and lives, and shortens the
// play window as rounds accumulate.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES         = DEF_LIVES,
  parameter int unsigned START_TIME    = DEF_START_TIME,
  parameter int unsigned MIN_TIME      = DEF_MIN_TIME,
  parameter int unsigned SPEEDUP_EVERY = 4,
  parameter int unsigned GAP_TICKS     = DEF_GAP_TICKS,
  parameter int unsigned COUNT_TICKS   = 3,
  parameter int unsigned SCORE_W       = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               INIT_n,
  input  logic               tick,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic               gameState,
  output logic [PHASE_W-1:0] roundTime,
  output logic [PHASE_W-1:0] remaining,
  output logic [SCORE_W-1:0] round_num,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               new_round,
  output logic               game_over
);

  // Parameters resized once to the widths they are compared against.
  localparam logic [LIVES_W-1:0] LIVES_V = LIVES_W'(LIVES);
  localparam logic [PHASE_W-1:0] START_V = PHASE_W'(START_TIME);
  localparam logic [PHASE_W-1:0] MIN_V   = PHASE_W'(MIN_TIME);
  localparam logic [PHASE_W-1:0] GAP_V   = PHASE_W'(GAP_TICKS);
  localparam logic [PHASE_W-1:0] COUNT_V = PHASE_W'(COUNT_TICKS);
  localparam logic [SCORE_W-1:0] SPEED_V = SCORE_W'(SPEEDUP_EVERY);

  state_t             state, state_nx;
  logic [SCORE_W-1:0] score_nx, round_nx;
  logic [LIVES_W-1:0] lives_nx;
  logic [PHASE_W-1:0] round_time_nx;
  logic               new_round_nx;

  logic               cnt_load;
  logic [PHASE_W-1:0] cnt_value;
  logic               cnt_en;
  logic               cnt_expire;

  logic               resolve;
  logic               lose_life;

  // The shared phase timer only runs while a timed phase is active.
  assign cnt_en = tick && ((state == ST_COUNT) || (state == ST_PLAY) ||
                           (state == ST_GAP));

  // A round ends on the first of miss, hit or timeout; miss outranks hit,
  // and only a miss or a timeout costs a life.
  assign resolve   = (state == ST_PLAY) && (miss || hit || cnt_expire);
  assign lose_life = (state == ST_PLAY) && (miss || (!hit && cnt_expire));

  phase_counter u_phase_counter (
    .clk        (clk),
    .rst_n      (INIT_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .en         (cnt_en),
    .remaining  (remaining),
    .expire     (cnt_expire)
  );

  // Next-state, scoring, lives, speed-up and phase-timer load decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (which would infer a latch).
    state_nx      = state;
    score_nx      = score;
    round_nx      = round_num;
    lives_nx      = lives;
    round_time_nx = roundTime;
    new_round_nx  = 1'b0;
    cnt_load      = 1'b0;
    cnt_value     = '0;

    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_nx      = ST_COUNT;
          score_nx      = '0;
          round_nx      = '0;
          lives_nx      = LIVES_V;
          round_time_nx = START_V;
          cnt_load      = 1'b1;
          cnt_value     = COUNT_V;
        end
      end

      ST_COUNT, ST_GAP: begin
        if (cnt_expire) begin
          state_nx     = ST_PLAY;
          round_nx     = (round_num == '1) ? round_num
                                           : round_num + SCORE_W'(1);
          new_round_nx = 1'b1;
          cnt_load     = 1'b1;
          cnt_value    = roundTime;
        end
      end

      ST_PLAY: begin
        if (lose_life) begin
          lives_nx = lives - LIVES_W'(1);
        end
        if (hit && !miss) begin
          score_nx = (score == '1) ? score : score + SCORE_W'(1);
        end
        if (resolve) begin
          cnt_load = 1'b1;
          if (lose_life && (lives == LIVES_W'(1))) begin
            state_nx  = ST_OVER;
            cnt_value = '0;
          end else begin
            state_nx  = ST_GAP;
            cnt_value = GAP_V;
            if (((round_num % SPEED_V) == '0) && (roundTime > MIN_V)) begin
              round_time_nx = roundTime - PHASE_W'(1);
            end
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; all flags derive from the next state.
  always_ff @(posedge clk or negedge INIT_n) begin
    if (!INIT_n) begin
      // NOTE: every register here has an explicit reset value; the design holds no memories that could legitimately skip reset.
      state     <= ST_IDLE;
      gameState <= 1'b0;
      roundTime <= START_V;
      round_num <= '0;
      score     <= '0;
      lives     <= LIVES_V;
      new_round <= 1'b0;
      game_over <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      state     <= state_nx;
      gameState <= (state_nx == ST_PLAY);
      roundTime <= round_time_nx;
      round_num <= round_nx;
      score     <= score_nx;
      lives     <= lives_nx;
      new_round <= new_round_nx;
      game_over <= (state_nx == ST_OVER);
    end
  end

endmodule
